// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: frame state encoding and serial line constants shared by the
// UART transmit controller and its parity helper.
package uart_tx_pkg;

   // state  | meaning
   // IDLE   | line idle high, waiting for Data_Valid
   // START  | driving the start bit (one cycle)
   // DATA   | shifting out data bits LSB-first, cnt selects the bit
   // PARITY | driving the parity bit (only built with UART_TX_PARITY_EN)
   // STOP   | driving the stop bit; a new word may be accepted here
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: combinational parity over the latched word.
// Even parity makes the total count of ones (data + parity) even; odd
// parity makes it odd.
import uart_tx_pkg::*;

module uart_tx_parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_par_typ,
   output logic                  o_parity
);

   logic w_xor;

   assign w_xor    = ^i_data;
   assign o_parity = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer. One serial bit per CLK edge:
// start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit.
// TX_OUT and Busy are registered from the next state so they show the bit of
// the state entered on each edge.
// Build option: define UART_TX_PARITY_EN to build the parity state, the
// parity XOR tree and the PAR_EN/PAR_TYP latches. Without it those ports
// are ignored and every frame is DATA_WIDTH+2 bits long.
import uart_tx_pkg::*;

module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_tx;
   logic                  r_busy;

   tx_state_e             w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;
   logic                  w_accept;

`ifdef UART_TX_PARITY_EN
   logic r_par_en;
   logic r_par_typ;
   logic w_par_en_nxt;
   logic w_par_typ_nxt;
   logic w_parity;

   uart_tx_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .i_data    (r_data),
      .i_par_typ (r_par_typ),
      .o_parity  (w_parity)
   );
`else
   // Parity ports are kept for interface compatibility but have no load.
   logic w_unused_par;
   assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

   // Next-state, counter, capture and registered-output selection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_accept    = 1'b0;
      w_tx_nxt    = LINE_IDLE;
      w_busy_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_en_nxt  = r_par_en;
      w_par_typ_nxt = r_par_typ;
`endif

      case (r_state)
         IDLE: begin
            if (Data_Valid) begin
               w_accept    = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            w_state_nxt = DATA;
            w_cnt_nxt   = '0;
         end
         DATA: begin
            if (r_cnt == LAST_CNT) begin
               // Clear so the next frame always starts from bit 0.
               w_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
               w_state_nxt = r_par_en ? PARITY : STOP;
`else
               w_state_nxt = STOP;
`endif
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            w_state_nxt = STOP;
         end
`endif
         STOP: begin
            if (Data_Valid) begin
               w_accept    = 1'b1;
               w_state_nxt = START;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_accept) begin
         w_data_nxt = P_DATA;
`ifdef UART_TX_PARITY_EN
         w_par_en_nxt  = PAR_EN;
         w_par_typ_nxt = PAR_TYP;
`endif
      end

      case (w_state_nxt)
         START: begin
            w_tx_nxt   = START_BIT;
            w_busy_nxt = 1'b1;
         end
         DATA: begin
            w_tx_nxt   = w_data_nxt[w_cnt_nxt];
            w_busy_nxt = 1'b1;
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            // Word is unchanged between DATA and PARITY, so r_data is valid.
            w_tx_nxt   = w_parity;
            w_busy_nxt = 1'b1;
         end
`endif
         STOP: begin
            w_tx_nxt   = STOP_BIT;
            w_busy_nxt = 1'b1;
         end
         default: begin
            w_tx_nxt   = LINE_IDLE;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   // State, counter, latched word and registered line outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_tx    <= LINE_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity configuration captured with the word at acceptance.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
      end else begin
         r_par_en  <= w_par_en_nxt;
         r_par_typ <= w_par_typ_nxt;
      end
   end
`endif

   assign TX_OUT = r_tx;
   assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed and randomized frame checks for uart_tx_ctrl.
// The expected line waveform is derived from the frame rules (start, data
// LSB-first, optional parity by popcount, stop).
module tb_uart_tx_ctrl;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] P_DATA;
   logic         Data_Valid;
   logic         PAR_EN;
   logic         PAR_TYP;
   logic         TX_OUT;
   logic         Busy;

   int errors = 0;
   int checks = 0;

   uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   function automatic bit par_active(input logic pen);
`ifdef UART_TX_PARITY_EN
      return pen;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int frame_len(input logic pen);
      return W + 2 + (par_active(pen) ? 1 : 0);
   endfunction

   // Bit idx of the frame: 0 start, 1..W data LSB-first, then parity, stop.
   function automatic logic exp_bit(input logic [W-1:0] d, input logic pen,
                                    input logic ptyp, input int idx);
      int ones;
      if (idx == 0) return 1'b0;
      if (idx <= W) return d[idx-1];
      if (par_active(pen) && idx == W + 1) begin
         ones = 0;
         for (int k = 0; k < W; k++) ones += int'(d[k]);
         // even: parity bit makes total ones even; odd: makes it odd
         return ((ones % 2) == 1) ^ ptyp;
      end
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_tx"}, TX_OUT, 1'b1);
      chk({tag, "_busy"}, Busy, 1'b0);
   endtask

   // Called at a negedge: present a word, wait to the negedge after acceptance.
   task automatic start(input logic [W-1:0] d, input logic pen, input logic ptyp);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
      @(negedge CLK);
   endtask

   // Checks a frame bit by bit from the first negedge after acceptance.
   // Optionally pulses a junk request at bit junk_at, scrambles the parity
   // inputs mid-frame, and chains the next word during the stop bit.
   task automatic check_frame(input string tag, input logic [W-1:0] d,
                              input logic pen, input logic ptyp,
                              input bit chain, input logic [W-1:0] nd,
                              input logic npen, input logic nptyp,
                              input int junk_at);
      int n;
      n = frame_len(pen);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge CLK);
         chk($sformatf("%s_b%0d", tag, i), TX_OUT, exp_bit(d, pen, ptyp, i));
         chk($sformatf("%s_busy%0d", tag, i), Busy, 1'b1);
         Data_Valid = 1'b0;
         if (i == 2) begin
            PAR_EN  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
         end
         if (i == junk_at) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'h12;
         end
         if (i == n - 1 && chain) begin
            Data_Valid = 1'b1;
            P_DATA     = nd;
            PAR_EN     = npen;
            PAR_TYP    = nptyp;
         end
      end
   endtask

   initial begin
      logic [W-1:0] cd, nd;
      logic         cpen, cptyp, npen, nptyp;
      bit           chain;
      int           junk;

      RST        = 1'b0;
      P_DATA     = '0;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      #12;
      chk_idle("reset");
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk_idle("post_reset");

      // 1: A5 with even parity
      start(8'hA5, 1'b1, 1'b0);
      check_frame("a5_even", 8'hA5, 1'b1, 1'b0, 0, '0, 0, 0, -1);
      @(negedge CLK);
      chk_idle("a5_end");

      // 2: 3C without parity
      start(8'h3C, 1'b0, 1'b0);
      check_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 0, '0, 0, 0, -1);
      @(negedge CLK);
      chk_idle("3c_end");

      // 3: odd parity corner words
      start(8'h01, 1'b1, 1'b1);
      check_frame("01_odd", 8'h01, 1'b1, 1'b1, 0, '0, 0, 0, -1);
      @(negedge CLK);
      start(8'h00, 1'b1, 1'b1);
      check_frame("00_odd", 8'h00, 1'b1, 1'b1, 0, '0, 0, 0, -1);
      @(negedge CLK);
      chk_idle("odd_end");

      // 4: back-to-back 55 then FF accepted in STOP
      start(8'h55, 1'b1, 1'b0);
      check_frame("b2b_55", 8'h55, 1'b1, 1'b0, 1, 8'hFF, 1'b1, 1'b1, -1);
      @(negedge CLK);
      check_frame("b2b_ff", 8'hFF, 1'b1, 1'b1, 0, '0, 0, 0, -1);
      @(negedge CLK);
      chk_idle("b2b_end");

      // 5: request during DATA is ignored
      start(8'hA5, 1'b0, 1'b0);
      check_frame("junk_a5", 8'hA5, 1'b0, 1'b0, 0, '0, 0, 0, 4);
      @(negedge CLK);
      chk_idle("junk_end");
      repeat (3) @(negedge CLK);
      chk_idle("junk_quiet");

      // 6: async reset during the 4th data bit (frame bit index 4)
      start(8'hA5, 1'b1, 1'b0);
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) @(negedge CLK);
         chk($sformatf("rst_b%0d", i), TX_OUT, exp_bit(8'hA5, 1'b1, 1'b0, i));
         Data_Valid = 1'b0;
      end
      #1 RST = 1'b0;
      #1;
      chk_idle("rst_async");
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk_idle("rst_release");
      start(8'hA5, 1'b1, 1'b0);
      check_frame("rst_a5", 8'hA5, 1'b1, 1'b0, 0, '0, 0, 0, -1);
      @(negedge CLK);
      chk_idle("rst_a5_end");

      // Randomized frames, random chaining, random junk requests
      cd    = W'($urandom);
      cpen  = 1'($urandom_range(0, 1));
      cptyp = 1'($urandom_range(0, 1));
      start(cd, cpen, cptyp);
      for (int k = 0; k < 30; k++) begin
         nd    = W'($urandom);
         npen  = 1'($urandom_range(0, 1));
         nptyp = 1'($urandom_range(0, 1));
         chain = (k < 29) && ($urandom_range(0, 1) == 1);
         junk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, W)) : -1;
         check_frame($sformatf("rnd%0d", k), cd, cpen, cptyp, chain, nd, npen, nptyp, junk);
         @(negedge CLK);
         if (!chain) begin
            chk_idle($sformatf("rnd%0d_idle", k));
            if (k < 29) begin
               repeat ($urandom_range(0, 2)) @(negedge CLK);
               start(nd, npen, nptyp);
            end
         end
         cd    = nd;
         cpen  = npen;
         cptyp = nptyp;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
